// File: rtl/hs_npu_requant_unit_pkg.sv
// Shared types and the requantization arithmetic for the NPU requant unit.
// The per-sample math lives here so that every lane computes it the same way.
package hs_npu_requant_unit_pkg;

    localparam int IN_WIDTH   = 32;
    localparam int OUT_WIDTH  = 16;
    localparam int SHIFT_W    = $clog2(IN_WIDTH);
    localparam int SIZE_DEF   = 8;
    localparam int DEPTH_DEF  = 4;

    typedef struct packed {
        logic [SHIFT_W-1:0] shift;
        logic               relu_en;
    } requant_cfg_t;

    // Saturation bounds held at the IN_WIDTH+1 working width.
    localparam logic signed [IN_WIDTH:0] SAT_MAX =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] SAT_MIN =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [IN_WIDTH:0] RND_ONE = 1;

    // Round-half-up arithmetic shift, optional ReLU, then clamp to OUT_WIDTH.
    function automatic logic [OUT_WIDTH-1:0] sat_round_shift(
        input logic signed [IN_WIDTH-1:0] x,
        input logic        [SHIFT_W-1:0]  shift,
        input logic                       relu_en
    );
        logic signed [IN_WIDTH:0] ext;
        logic signed [IN_WIDTH:0] bias;
        logic signed [IN_WIDTH:0] r;
        logic        [OUT_WIDTH-1:0] res;
        ext  = {x[IN_WIDTH-1], x};
        bias = RND_ONE << (shift - 1'b1);
        r    = (shift == '0) ? ext : ((ext + bias) >>> shift);
        if (relu_en && r[IN_WIDTH]) begin
            r = '0;
        end
        if (r > SAT_MAX) begin
            res = SAT_MAX[OUT_WIDTH-1:0];
        end else if (r < SAT_MIN) begin
            res = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            res = r[OUT_WIDTH-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/hs_npu_requant_unit_if.sv
// Lane-sample input bus from the MM unit and row output handshake towards the FIFO.
interface hs_npu_requant_unit_if
    import hs_npu_requant_unit_pkg::*;
#(
    parameter int SIZE = SIZE_DEF
);
    logic [SIZE-1:0][IN_WIDTH-1:0]  data_i;
    logic [SIZE-1:0]                valid_i;
    logic [SIZE-1:0][OUT_WIDTH-1:0] data_o;
    logic                           valid_o;
    logic                           ready_i;

    // Producer of samples and consumer of rows, as seen from the environment.
    modport master (
        output data_i, valid_i, ready_i,
        input  data_o, valid_o
    );

    modport slave (
        input  data_i, valid_i, ready_i,
        output data_o, valid_o
    );
endinterface

// File: rtl/hs_npu_requant_unit_lane.sv
// One lane's stage-1 register: requantizes a sample in the cycle it arrives.
module hs_npu_requant_unit_lane
    import hs_npu_requant_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 valid,
    input  logic [IN_WIDTH-1:0]  data,
    input  requant_cfg_t         cfg,
    output logic                 valid_q,
    output logic [OUT_WIDTH-1:0] data_q
);

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid;
            if (valid) begin
                data_q <= sat_round_shift(data, cfg.shift, cfg.relu_en);
            end
        end
    end

endmodule

// File: rtl/hs_npu_requant_unit.sv
// Requantizes skewed MM lane outputs and re-aligns them into whole rows
// in a DEPTH-slot buffer, emitting rows in order over valid/ready.
module hs_npu_requant_unit
    import hs_npu_requant_unit_pkg::*;
#(
    parameter int SIZE  = SIZE_DEF,
    parameter int DEPTH = DEPTH_DEF
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [SHIFT_W-1:0]  shift_i,
    input  logic                relu_en_i,
    output logic                overflow_o,
    output logic                busy_o,
    hs_npu_requant_unit_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);

    requant_cfg_t                             cfg;
    logic [SIZE-1:0]                          s_valid;
    logic [SIZE-1:0][OUT_WIDTH-1:0]           s_data;
    logic [DEPTH-1:0][SIZE-1:0][OUT_WIDTH-1:0] row_buf;
    logic [DEPTH-1:0][SIZE-1:0]               mask;
    logic [DEPTH-1:0][SIZE-1:0]               mask_next;
    logic [SIZE-1:0][PTR_W-1:0]               wp;
    logic [PTR_W-1:0]                         rd;
    logic [SIZE-1:0]                          wr_en;
    logic                                     ovf_set;
    logic                                     pop;

    assign cfg = '{shift: shift_i, relu_en: relu_en_i};

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        hs_npu_requant_unit_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .valid   (bus.valid_i[i]),
            .data    (bus.data_i[i]),
            .cfg     (cfg),
            .valid_q (s_valid[i]),
            .data_q  (s_data[i])
        );
    end

    assign bus.valid_o = &mask[rd];
    assign bus.data_o  = row_buf[rd];
    assign pop         = bus.valid_o && bus.ready_i;
    assign busy_o      = (|s_valid) || (|mask);

    // The pop clears the read slot before lane writes are checked, so a write
    // landing on the slot being popped this cycle is accepted.
    // NOTE: combinational logic uses = and assigns every output a default first, so no latch is inferred.
    always_comb begin
        mask_next = mask;
        wr_en     = '0;
        ovf_set   = 1'b0;
        if (pop) begin
            mask_next[rd] = '0;
        end
        for (int i = 0; i < SIZE; i++) begin
            if (s_valid[i]) begin
                if (!mask_next[wp[i]][i]) begin
                    wr_en[i]            = 1'b1;
                    mask_next[wp[i]][i] = 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
    end

    // NOTE: the row storage is cleared on rst/flush because data_o reads it directly and must be 0 after reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mask       <= '0;
            wp         <= '0;
            rd         <= '0;
            row_buf    <= '0;
            overflow_o <= 1'b0;
        end else begin
            mask <= mask_next;
            if (pop) begin
                rd <= rd + 1'b1;
            end
            for (int i = 0; i < SIZE; i++) begin
                if (wr_en[i]) begin
                    row_buf[wp[i]][i] <= s_data[i];
                    wp[i]             <= wp[i] + 1'b1;
                end
            end
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hs_npu_requant_unit.sv
// Directed bench for hs_npu_requant_unit: skew alignment, rounding, saturation,
// backpressure/overflow, mid-row reset, flush and pop/write collision.
module tb_hs_npu_requant_unit;
    import hs_npu_requant_unit_pkg::*;

    logic               clk;
    logic               rst;
    logic               flush;
    logic [SHIFT_W-1:0] shift_i;
    logic               relu_en_i;
    logic               overflow_o;
    logic               busy_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0][31:0] v;
    logic [7:0][15:0] e;

    hs_npu_requant_unit_if #(.SIZE(8)) bus ();

    hs_npu_requant_unit #(.SIZE(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .shift_i    (shift_i),
        .relu_en_i  (relu_en_i),
        .overflow_o (overflow_o),
        .busy_o     (busy_o),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a set of lane samples for exactly one cycle.
    task automatic drive(input logic [7:0] lanes, input logic [7:0][31:0] vals);
        bus.valid_i = lanes;
        bus.data_i  = vals;
        tick();
        bus.valid_i = '0;
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        shift_i     = '0;
        relu_en_i   = 1'b0;
        bus.valid_i = '0;
        bus.data_i  = '0;
        bus.ready_i = 1'b1;
        tick();
        tick();
        check("rst_valid", 128'(bus.valid_o), 128'(0));
        check("rst_data", bus.data_o, 128'(0));
        check("rst_ovf", 128'(overflow_o), 128'(0));
        check("rst_busy", 128'(busy_o), 128'(0));
        rst = 1'b0;

        // Skew: lane c valid in cycle c, row completes two cycles after lane 7.
        for (int c = 0; c < 8; c++) begin
            bus.valid_i    = 8'(1 << c);
            bus.data_i[c]  = 32'(100 * (c + 1));
            tick();
        end
        bus.valid_i = '0;
        check("skew_partial", 128'(bus.valid_o), 128'(0));
        check("skew_busy", 128'(busy_o), 128'(1));
        tick();
        for (int i = 0; i < 8; i++) e[i] = 16'(100 * (i + 1));
        check("skew_valid", 128'(bus.valid_o), 128'(1));
        check("skew_data", bus.data_o, e);
        tick();
        check("skew_pulse", 128'(bus.valid_o), 128'(0));
        check("skew_idle", 128'(busy_o), 128'(0));

        // Rounding with shift=4.
        shift_i = 5'd4;
        v = '0;
        v[0] = 32'(24); v[1] = 32'(23); v[2] = 32'(-24); v[3] = 32'(-25);
        v[4] = 32'(40); v[5] = 32'(7);  v[6] = 32'(8);   v[7] = 32'(-8);
        drive(8'hFF, v);
        shift_i = '0;
        tick();
        e[0] = 16'(2); e[1] = 16'(1); e[2] = 16'(-1); e[3] = 16'(-2);
        e[4] = 16'(3); e[5] = 16'(0); e[6] = 16'(1);  e[7] = 16'(0);
        check("round_valid", 128'(bus.valid_o), 128'(1));
        check("round_data", bus.data_o, e);
        tick();

        // Saturation with shift=0.
        v[0] = 32'(70000); v[1] = 32'(-70000); v[2] = 32'(5);     v[3] = 32'(-5);
        v[4] = 32'(32767); v[5] = 32'(-32768); v[6] = 32'(32768); v[7] = 32'(0);
        drive(8'hFF, v);
        tick();
        e[0] = 16'(32767); e[1] = 16'(-32768); e[2] = 16'(5);     e[3] = 16'(-5);
        e[4] = 16'(32767); e[5] = 16'(-32768); e[6] = 16'(32767); e[7] = 16'(0);
        check("sat_data", bus.data_o, e);
        tick();

        // ReLU with saturation.
        relu_en_i = 1'b1;
        v[0] = 32'(-70000); v[1] = 32'(5);  v[2] = 32'(70000); v[3] = 32'(-1);
        v[4] = 32'(0);      v[5] = 32'(-5); v[6] = 32'(32768); v[7] = 32'(9);
        drive(8'hFF, v);
        relu_en_i = 1'b0;
        tick();
        e[0] = 16'(0); e[1] = 16'(5); e[2] = 16'(32767); e[3] = 16'(0);
        e[4] = 16'(0); e[5] = 16'(0); e[6] = 16'(32767); e[7] = 16'(9);
        check("relu_data", bus.data_o, e);
        tick();

        // Backpressure: fill all four slots, then overrun lane 0.
        bus.ready_i = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) v[i] = 32'(1000 * r + i);
            drive(8'hFF, v);
        end
        tick();
        for (int i = 0; i < 8; i++) e[i] = 16'(i);
        check("bp_valid", 128'(bus.valid_o), 128'(1));
        check("bp_row0", bus.data_o, e);
        check("bp_no_ovf", 128'(overflow_o), 128'(0));
        v = '0;
        v[0] = 32'(9999);
        drive(8'h01, v);
        tick();
        check("bp_ovf", 128'(overflow_o), 128'(1));
        check("bp_hold", bus.data_o, e);
        bus.ready_i = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) e[i] = 16'(1000 * r + i);
            check($sformatf("bp_drain_valid%0d", r), 128'(bus.valid_o), 128'(1));
            check($sformatf("bp_drain_row%0d", r), bus.data_o, e);
            tick();
        end
        check("bp_empty", 128'(bus.valid_o), 128'(0));
        check("bp_dropped", 128'(busy_o), 128'(0));
        check("bp_sticky", 128'(overflow_o), 128'(1));

        // Reset in the middle of a row.
        for (int i = 0; i < 8; i++) v[i] = 32'(50 + i);
        drive(8'h0F, v);
        tick();
        check("mid_busy", 128'(busy_o), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_valid", 128'(bus.valid_o), 128'(0));
        check("mid_ovf", 128'(overflow_o), 128'(0));
        check("mid_busy0", 128'(busy_o), 128'(0));
        for (int i = 0; i < 8; i++) v[i] = 32'(11 * (i + 1));
        drive(8'hFF, v);
        tick();
        for (int i = 0; i < 8; i++) e[i] = 16'(11 * (i + 1));
        check("mid_row_valid", 128'(bus.valid_o), 128'(1));
        check("mid_row_data", bus.data_o, e);
        tick();
        check("mid_row_alone", 128'(bus.valid_o), 128'(0));

        // Flush wins over a same-cycle sample.
        bus.ready_i = 1'b0;
        drive(8'hFF, v);
        tick();
        check("fl_valid", 128'(bus.valid_o), 128'(1));
        flush          = 1'b1;
        bus.valid_i    = 8'h01;
        bus.data_i[0]  = 32'(5);
        tick();
        flush       = 1'b0;
        bus.valid_i = '0;
        check("fl_cleared", 128'(bus.valid_o), 128'(0));
        check("fl_data", bus.data_o, 128'(0));
        tick();
        check("fl_dropped", 128'(busy_o), 128'(0));

        // Pop of slot 0 coincides with lane 0 writing its fifth sample there.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) v[i] = 32'(100 * r + i);
            drive(8'hFF, v);
        end
        tick();
        v = '0;
        v[0] = 32'(777);
        drive(8'h01, v);
        bus.ready_i = 1'b1;
        for (int i = 0; i < 8; i++) e[i] = 16'(i);
        check("col_row0", bus.data_o, e);
        tick();
        check("col_no_ovf", 128'(overflow_o), 128'(0));
        for (int i = 0; i < 8; i++) e[i] = 16'(100 + i);
        check("col_row1", bus.data_o, e);
        for (int i = 1; i < 8; i++) v[i] = 32'(400 + i);
        drive(8'hFE, v);
        for (int i = 0; i < 8; i++) e[i] = 16'(200 + i);
        check("col_row2", bus.data_o, e);
        tick();
        for (int i = 0; i < 8; i++) e[i] = 16'(300 + i);
        check("col_row3", bus.data_o, e);
        tick();
        e[0] = 16'(777);
        for (int i = 1; i < 8; i++) e[i] = 16'(400 + i);
        check("col_row4_valid", 128'(bus.valid_o), 128'(1));
        check("col_row4", bus.data_o, e);
        tick();
        check("col_empty", 128'(bus.valid_o), 128'(0));
        check("col_idle", 128'(busy_o), 128'(0));
        check("col_ovf_end", 128'(overflow_o), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
